// File: rtl/tempo_pkg.sv
// Shared tempo definitions: BPM preset table, preset-step encoding and the
// BPM-to-period conversion used to build the period lookup at elaboration.
package tempo_pkg;

  localparam int unsigned MAX_TEMPOS = 8;

  localparam int unsigned TEMPO_BPM [0:MAX_TEMPOS-1] = '{
    240, 120, 100, 75, 180, 150, 90, 60
  };

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } step_t;

  // Beat period minus one, in clock cycles, for a given clock rate and BPM.
  function automatic longint unsigned bpm_to_period(input int unsigned clk_hz,
                                                    input int unsigned bpm);
    return (64'(clk_hz) * 64'd60) / 64'(bpm) - 64'd1;
  endfunction

endpackage

// File: rtl/tempo_gen_beat_divider.sv
// Beat divider: counts clk cycles against the selected period and produces
// beat_pulse, the beat-in-measure index and the measure_pulse.
module beat_divider
  import tempo_pkg::*;
#(
  parameter int unsigned CNT_W             = 23,
  parameter int unsigned BEATS_PER_MEASURE = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 run,
  input  logic [CNT_W-1:0]                     period,
  input  logic                                 restart,
  output logic                                 beat_pulse,
  output logic [$clog2(BEATS_PER_MEASURE)-1:0] beat_idx,
  output logic                                 measure_pulse
);

  localparam int unsigned BEAT_W = $clog2(BEATS_PER_MEASURE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_MEASURE - 1);

  if (BEATS_PER_MEASURE < 2 || BEATS_PER_MEASURE > 16) begin : g_bpm_range
    $error("beat_divider: BEATS_PER_MEASURE must be in 2..16");
  end

  logic [CNT_W-1:0] cnt;

  // Terminal count takes priority over restart so a beat completing on the
  // same edge as a tempo change still pulses; the count reloads 0 either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      beat_pulse    <= 1'b0;
      beat_idx      <= '0;
      measure_pulse <= 1'b0;
    end else begin
      beat_pulse    <= 1'b0;
      measure_pulse <= 1'b0;
      if (!run) begin
        cnt <= '0;
      end else if (cnt >= period) begin
        cnt        <= '0;
        beat_pulse <= 1'b1;
        if (beat_idx == LAST_BEAT) begin
          beat_idx      <= '0;
          measure_pulse <= 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end else if (restart) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tempo_gen.sv
// Tempo selector: steps through the BPM preset table on button pulses,
// publishes the registered beat period and drives the beat divider.
module tempo_gen
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ            = 5_000_000,
  parameter int unsigned NUM_TEMPOS        = 4,
  parameter int unsigned CNT_W             = 23,
  parameter int unsigned BEATS_PER_MEASURE = 4,
  parameter bit          WRAP              = 1'b1,
  parameter int unsigned DEFAULT_IDX       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tempo_next,
  input  logic                                 tempo_prev,
  input  logic                                 run,
  output logic [$clog2(NUM_TEMPOS)-1:0]        tempo_idx,
  output logic [CNT_W-1:0]                     tempo,
  output logic                                 beat_pulse,
  output logic [$clog2(BEATS_PER_MEASURE)-1:0] beat_idx,
  output logic                                 measure_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_TEMPOS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEMPOS - 1);
  localparam logic [IDX_W-1:0] RST_IDX  = IDX_W'(DEFAULT_IDX);
  localparam longint unsigned MAX_PERIOD = (64'd1 << CNT_W) - 64'd1;

  if (NUM_TEMPOS < 2 || NUM_TEMPOS > MAX_TEMPOS) begin : g_num_range
    $error("tempo_gen: NUM_TEMPOS must be in 2..8");
  end

  if (DEFAULT_IDX >= NUM_TEMPOS) begin : g_def_range
    $error("tempo_gen: DEFAULT_IDX must be below NUM_TEMPOS");
  end

  logic [CNT_W-1:0] period_tab [NUM_TEMPOS];

  for (genvar g = 0; g < NUM_TEMPOS; g++) begin : g_tab
    localparam longint unsigned PERIOD =
      bpm_to_period(CLK_HZ, TEMPO_BPM[g % MAX_TEMPOS]);
    if (PERIOD > MAX_PERIOD) begin : g_ovf
      $error("tempo_gen: preset period does not fit in CNT_W bits");
    end
    assign period_tab[g] = CNT_W'(PERIOD);
  end

  step_t            step;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] tempo_q;
  logic             restart;

  always_comb begin
    step    = STEP_HOLD;
    idx_nxt = idx_q;
    if (tempo_next && !tempo_prev) begin
      step = STEP_NEXT;
    end else if (tempo_prev && !tempo_next) begin
      step = STEP_PREV;
    end
    case (step)
      STEP_NEXT: begin
        if (idx_q == LAST_IDX) begin
          idx_nxt = WRAP ? '0 : idx_q;
        end else begin
          idx_nxt = idx_q + 1'b1;
        end
      end
      STEP_PREV: begin
        if (idx_q == '0) begin
          idx_nxt = WRAP ? LAST_IDX : idx_q;
        end else begin
          idx_nxt = idx_q - 1'b1;
        end
      end
      default: idx_nxt = idx_q;
    endcase
  end

  // A saturated step leaves the index alone, so only a real change restarts.
  assign restart = (idx_nxt != idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= RST_IDX;
      tempo_q <= period_tab[RST_IDX];
    end else begin
      idx_q   <= idx_nxt;
      tempo_q <= period_tab[idx_nxt];
    end
  end

  assign tempo_idx = idx_q;
  assign tempo     = tempo_q;

  beat_divider #(
    .CNT_W             (CNT_W),
    .BEATS_PER_MEASURE (BEATS_PER_MEASURE)
  ) u_beat_divider (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .period        (tempo_q),
    .restart       (restart),
    .beat_pulse    (beat_pulse),
    .beat_idx      (beat_idx),
    .measure_pulse (measure_pulse)
  );

endmodule

// File: tb/tb_tempo_gen.sv
// Directed bench for tempo_gen at CLK_HZ=600 (periods 149/299/359/479),
// with a wrapping and a saturating instance.
module tb_tempo_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run;
  logic        nxt_w, prv_w, nxt_s, prv_s;
  logic [1:0]  idx_w, idx_s, bidx_w, bidx_s;
  logic [22:0] tempo_w, tempo_s;
  logic        bp_w, bp_s, mp_w, mp_s;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  tempo_gen #(.CLK_HZ(600), .WRAP(1)) dut_w (
    .clk           (clk),
    .rst           (rst),
    .tempo_next    (nxt_w),
    .tempo_prev    (prv_w),
    .run           (run),
    .tempo_idx     (idx_w),
    .tempo         (tempo_w),
    .beat_pulse    (bp_w),
    .beat_idx      (bidx_w),
    .measure_pulse (mp_w)
  );

  tempo_gen #(.CLK_HZ(600), .WRAP(0)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .tempo_next    (nxt_s),
    .tempo_prev    (prv_s),
    .run           (run),
    .tempo_idx     (idx_s),
    .tempo         (tempo_s),
    .beat_pulse    (bp_s),
    .beat_idx      (bidx_s),
    .measure_pulse (mp_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts negedges until beat_pulse of the wrapping instance is seen.
  task automatic wait_pulse(input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit) begin
      @(negedge clk);
      cnt++;
      if (bp_w) break;
    end
  endtask

  task automatic pulse_w(input logic nx, input logic pv);
    nxt_w = nx;
    prv_w = pv;
    @(negedge clk);
    nxt_w = 1'b0;
    prv_w = 1'b0;
  endtask

  task automatic pulse_s(input logic nx, input logic pv);
    nxt_s = nx;
    prv_s = pv;
    @(negedge clk);
    nxt_s = 1'b0;
    prv_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0;
    nxt_w = 1'b0; prv_w = 1'b0; nxt_s = 1'b0; prv_s = 1'b0;
    cycles(2);
    check("rst_idx",     32'(idx_w),   0);
    check("rst_tempo",   32'(tempo_w), 149);
    check("rst_bp",      32'(bp_w),    0);
    check("rst_bidx",    32'(bidx_w),  0);
    check("rst_mp",      32'(mp_w),    0);
    check("rst_tempo_s", 32'(tempo_s), 149);
    rst = 1'b0;
    cycles(1);

    // saturating instance
    pulse_s(1'b0, 1'b1);
    check("sat_prev_idx",   32'(idx_s),   0);
    check("sat_prev_tempo", 32'(tempo_s), 149);
    pulse_s(1'b1, 1'b0); check("sat_n1_tempo", 32'(tempo_s), 299);
    pulse_s(1'b1, 1'b0); check("sat_n2_tempo", 32'(tempo_s), 359);
    pulse_s(1'b1, 1'b0);
    check("sat_n3_idx",   32'(idx_s),   3);
    check("sat_n3_tempo", 32'(tempo_s), 479);
    pulse_s(1'b1, 1'b0);
    check("sat_n4_idx",   32'(idx_s),   3);
    check("sat_n4_tempo", 32'(tempo_s), 479);
    check("idle_no_pulse", 32'(bp_w), 0);

    // free-running measure at 149
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(1000, n);
      check("t1_interval", n, 150);
      check("t1_bidx", 32'(bidx_w), (i + 1) % 4);
      check("t1_mp",   32'(mp_w),   (i == 3) ? 1 : 0);
    end

    // both buttons together: no change, no restart
    pulse_w(1'b1, 1'b1);
    check("both_idx",   32'(idx_w),   0);
    check("both_tempo", 32'(tempo_w), 149);
    wait_pulse(1000, n);
    check("both_interval", n, 149);
    check("both_bidx", 32'(bidx_w), 1);

    // change at count 100: partial beat dropped
    cycles(100);
    pulse_w(1'b1, 1'b0);
    check("mid_idx",   32'(idx_w),   1);
    check("mid_tempo", 32'(tempo_w), 299);
    check("mid_bidx",  32'(bidx_w),  1);
    wait_pulse(1000, n);
    check("mid_interval", n, 300);
    check("mid_bidx2", 32'(bidx_w), 2);

    // wrap through the table
    pulse_w(1'b1, 1'b0); check("w_n2_tempo", 32'(tempo_w), 359);
    pulse_w(1'b1, 1'b0); check("w_n3_tempo", 32'(tempo_w), 479);
    pulse_w(1'b1, 1'b0);
    check("w_n4_idx",   32'(idx_w),   0);
    check("w_n4_tempo", 32'(tempo_w), 149);
    pulse_w(1'b0, 1'b1);
    check("w_prev_idx",   32'(idx_w),   3);
    check("w_prev_tempo", 32'(tempo_w), 479);
    wait_pulse(1000, n);
    check("w_interval", n, 480);
    check("w_bidx", 32'(bidx_w), 3);

    // change on the terminal-count edge keeps the completed beat
    cycles(479);
    pulse_w(1'b1, 1'b0);
    check("term_bp",    32'(bp_w),    1);
    check("term_mp",    32'(mp_w),    1);
    check("term_bidx",  32'(bidx_w),  0);
    check("term_idx",   32'(idx_w),   0);
    check("term_tempo", 32'(tempo_w), 149);
    wait_pulse(1000, n);
    check("term_interval", n, 150);
    wait_pulse(1000, n);
    check("pre_rst_bidx", 32'(bidx_w), 2);

    // reset mid-measure with run held
    pulse_w(1'b1, 1'b0);
    check("pre_rst_idx", 32'(idx_w), 1);
    cycles(80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_idx",   32'(idx_w),   0);
    check("mrst_tempo", 32'(tempo_w), 149);
    check("mrst_bp",    32'(bp_w),    0);
    check("mrst_bidx",  32'(bidx_w),  0);
    check("mrst_mp",    32'(mp_w),    0);
    wait_pulse(1000, n);
    check("mrst_interval", n, 150);
    check("mrst_bidx1", 32'(bidx_w), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
